id_ex_register: RTL and testbench

ID_EX_REGISTER -- requirements
Module: id_ex_register

---
 rtl/core_pkg.sv | 40 ++++
 rtl/hazard_detect.sv | 44 ++++
 rtl/id_ex_register.sv | 147 ++++++++++++++
 tb/tb_id_ex_register.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: ALU control encodings, the EX control vector and
// the bubble value it takes when a stage is squashed.
package core_pkg;

    localparam int unsigned ALU_CTRL_W = 3;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SRL = 3'd7
    } alu_ctrl_e;

    typedef struct packed {
        logic      reg_write;
        logic      mem_read;
        logic      mem_write;
        logic      alu_src;
        alu_ctrl_e alu_ctrl;
    } ex_ctrl_t;

    // A bubble must never write the register file or touch memory.
    localparam ex_ctrl_t BUBBLE_CTRL = '{
        reg_write: 1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        alu_src:   1'b0,
        alu_ctrl:  ALU_ADD
    };

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detection and writeback-to-decode operand bypass.
module hazard_detect #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] A1_D,
    input  logic [ADDR_W-1:0] A2_D,
    input  logic [DATA_W-1:0] RD1_D,
    input  logic [DATA_W-1:0] RD2_D,
    input  logic [ADDR_W-1:0] A3_W,
    input  logic [DATA_W-1:0] WD3_W,
    input  logic              WE3_W,
    input  logic [ADDR_W-1:0] rd_E,
    input  logic              MemRead_E,
    input  logic              valid_E,
    output logic [DATA_W-1:0] op1_c,
    output logic [DATA_W-1:0] op2_c,
    output logic              hazard_c
);

    logic wb_live_c;

    assign wb_live_c = WE3_W && (A3_W != '0);

    // x0 always reads as zero, whatever the register file or writeback says.
    always_comb begin
        op1_c = RD1_D;
        op2_c = RD2_D;
        if (A1_D == '0) begin
            op1_c = '0;
        end else if (wb_live_c && (A3_W == A1_D)) begin
            op1_c = WD3_W;
        end
        if (A2_D == '0) begin
            op2_c = '0;
        end else if (wb_live_c && (A3_W == A2_D)) begin
            op2_c = WD3_W;
        end
    end

    assign hazard_c = MemRead_E && valid_E && (rd_E != '0) &&
                      ((rd_E == A1_D) || (rd_E == A2_D));

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use stall, branch flush and a saturating
// bubble counter.
module id_ex_register
    import core_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     A1_D,
    input  logic [ADDR_W-1:0]     A2_D,
    input  logic [ADDR_W-1:0]     rd_D,
    input  logic [DATA_W-1:0]     RD1_D,
    input  logic [DATA_W-1:0]     RD2_D,
    input  logic [DATA_W-1:0]     imm_D,
    input  logic [DATA_W-1:0]     pc_D,
    input  logic                  RegWrite_D,
    input  logic                  MemRead_D,
    input  logic                  MemWrite_D,
    input  logic                  ALUSrc_D,
    input  logic [ALU_CTRL_W-1:0] ALUControl_D,
    input  logic [ADDR_W-1:0]     A3_W,
    input  logic [DATA_W-1:0]     WD3_W,
    input  logic                  WE3_W,
    input  logic                  flush_E,
    output logic                  stall_D,
    output logic [ADDR_W-1:0]     A1_E,
    output logic [ADDR_W-1:0]     A2_E,
    output logic [ADDR_W-1:0]     rd_E,
    output logic [DATA_W-1:0]     RD1_E,
    output logic [DATA_W-1:0]     RD2_E,
    output logic [DATA_W-1:0]     imm_E,
    output logic [DATA_W-1:0]     pc_E,
    output logic                  RegWrite_E,
    output logic                  MemRead_E,
    output logic                  MemWrite_E,
    output logic                  ALUSrc_E,
    output logic [ALU_CTRL_W-1:0] ALUControl_E,
    output logic                  valid_E,
    output logic [CNT_W-1:0]      bubble_cnt
);

    logic [ADDR_W-1:0] a1_d, a1_q, a2_d, a2_q, rd_d, rd_q;
    logic [DATA_W-1:0] rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q, pc_d, pc_q;
    ex_ctrl_t          ctrl_d, ctrl_q;
    logic              valid_d, valid_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;

    logic [DATA_W-1:0] op1_c, op2_c;
    logic              hazard_c;
    logic              bubble_c;

    hazard_detect #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_hazard_detect (
        .A1_D      (A1_D),
        .A2_D      (A2_D),
        .RD1_D     (RD1_D),
        .RD2_D     (RD2_D),
        .A3_W      (A3_W),
        .WD3_W     (WD3_W),
        .WE3_W     (WE3_W),
        .rd_E      (rd_q),
        .MemRead_E (ctrl_q.mem_read),
        .valid_E   (valid_q),
        .op1_c     (op1_c),
        .op2_c     (op2_c),
        .hazard_c  (hazard_c)
    );

    // Flush and hazard in the same cycle produce one bubble.
    assign bubble_c = flush_E || hazard_c;
    assign stall_D  = hazard_c;

    always_comb begin
        a1_d    = A1_D;
        a2_d    = A2_D;
        rd_d    = rd_D;
        rd1_d   = op1_c;
        rd2_d   = op2_c;
        imm_d   = imm_D;
        pc_d    = pc_D;
        ctrl_d  = '{reg_write: RegWrite_D,
                    mem_read:  MemRead_D,
                    mem_write: MemWrite_D,
                    alu_src:   ALUSrc_D,
                    alu_ctrl:  alu_ctrl_e'(ALUControl_D)};
        valid_d = 1'b1;
        cnt_d   = cnt_q;
        if (bubble_c) begin
            a1_d    = '0;
            a2_d    = '0;
            rd_d    = '0;
            rd1_d   = '0;
            rd2_d   = '0;
            imm_d   = '0;
            pc_d    = '0;
            ctrl_d  = BUBBLE_CTRL;
            valid_d = 1'b0;
            cnt_d   = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a1_q    <= '0;
            a2_q    <= '0;
            rd_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            ctrl_q  <= BUBBLE_CTRL;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            rd_q    <= rd_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign A1_E         = a1_q;
    assign A2_E         = a2_q;
    assign rd_E         = rd_q;
    assign RD1_E        = rd1_q;
    assign RD2_E        = rd2_q;
    assign imm_E        = imm_q;
    assign pc_E         = pc_q;
    assign RegWrite_E   = ctrl_q.reg_write;
    assign MemRead_E    = ctrl_q.mem_read;
    assign MemWrite_E   = ctrl_q.mem_write;
    assign ALUSrc_E     = ctrl_q.alu_src;
    assign ALUControl_E = ctrl_q.alu_ctrl;
    assign valid_E      = valid_q;
    assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Bench for id_ex_register: directed vector table, random stimulus against a
// behavioural pipeline model, counter saturation and mid-stall reset.
module tb_id_ex_register;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1_D, A2_D, rd_D, A3_W;
    logic [31:0] RD1_D, RD2_D, imm_D, pc_D, WD3_W;
    logic        RegWrite_D, MemRead_D, MemWrite_D, ALUSrc_D, WE3_W, flush_E;
    logic [2:0]  ALUControl_D;
    logic        stall_D;
    logic [4:0]  A1_E, A2_E, rd_E;
    logic [31:0] RD1_E, RD2_E, imm_E, pc_E;
    logic        RegWrite_E, MemRead_E, MemWrite_E, ALUSrc_E, valid_E;
    logic [2:0]  ALUControl_E;
    logic [15:0] bubble_cnt;

    int n_checks = 0;
    int n_errors = 0;

    id_ex_register dut (
        .clk(clk), .reset(reset),
        .A1_D(A1_D), .A2_D(A2_D), .rd_D(rd_D), .RD1_D(RD1_D), .RD2_D(RD2_D),
        .imm_D(imm_D), .pc_D(pc_D), .RegWrite_D(RegWrite_D), .MemRead_D(MemRead_D),
        .MemWrite_D(MemWrite_D), .ALUSrc_D(ALUSrc_D), .ALUControl_D(ALUControl_D),
        .A3_W(A3_W), .WD3_W(WD3_W), .WE3_W(WE3_W), .flush_E(flush_E),
        .stall_D(stall_D), .A1_E(A1_E), .A2_E(A2_E), .rd_E(rd_E),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .imm_E(imm_E), .pc_E(pc_E),
        .RegWrite_E(RegWrite_E), .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E),
        .ALUSrc_E(ALUSrc_E), .ALUControl_E(ALUControl_E), .valid_E(valid_E),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of what EX should hold.
    logic [4:0]  m_a1, m_a2, m_rd;
    logic [31:0] m_rd1, m_rd2, m_imm, m_pc;
    logic        m_rw, m_mr, m_mw, m_as, m_valid;
    logic [2:0]  m_alu;
    int          m_cnt;

    task automatic model_reset();
        m_a1 = 0; m_a2 = 0; m_rd = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_pc = 0;
        m_rw = 0; m_mr = 0; m_mw = 0; m_as = 0; m_alu = 0; m_valid = 0; m_cnt = 0;
    endtask

    function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rf);
        if (a == 0) return 32'd0;
        if (WE3_W && A3_W == a) return WD3_W;
        return rf;
    endfunction

    function automatic logic model_hazard();
        return m_valid && m_mr && (m_rd != 0) && (m_rd == A1_D || m_rd == A2_D);
    endfunction

    task automatic model_edge();
        if (flush_E || model_hazard()) begin
            model_reset_keep_cnt();
            if (m_cnt < 65535) m_cnt++;
        end else begin
            m_a1 = A1_D; m_a2 = A2_D; m_rd = rd_D;
            m_rd1 = operand(A1_D, RD1_D); m_rd2 = operand(A2_D, RD2_D);
            m_imm = imm_D; m_pc = pc_D; m_rw = RegWrite_D; m_mr = MemRead_D;
            m_mw = MemWrite_D; m_as = ALUSrc_D; m_alu = ALUControl_D; m_valid = 1;
        end
    endtask

    task automatic model_reset_keep_cnt();
        int c;
        c = m_cnt;
        model_reset();
        m_cnt = c;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, " A1_E"}, A1_E, m_a1);
        chk({tag, " A2_E"}, A2_E, m_a2);
        chk({tag, " rd_E"}, rd_E, m_rd);
        chk({tag, " RD1_E"}, RD1_E, m_rd1);
        chk({tag, " RD2_E"}, RD2_E, m_rd2);
        chk({tag, " imm_E"}, imm_E, m_imm);
        chk({tag, " pc_E"}, pc_E, m_pc);
        chk({tag, " ctrl_E"}, {RegWrite_E, MemRead_E, MemWrite_E, ALUSrc_E, ALUControl_E},
            {m_rw, m_mr, m_mw, m_as, m_alu});
        chk({tag, " valid_E"}, valid_E, m_valid);
        chk({tag, " bubble_cnt"}, bubble_cnt, 64'(m_cnt));
    endtask

    task automatic clear_inputs();
        A1_D = 0; A2_D = 0; rd_D = 0; RD1_D = 0; RD2_D = 0; imm_D = 0; pc_D = 0;
        RegWrite_D = 0; MemRead_D = 0; MemWrite_D = 0; ALUSrc_D = 0; ALUControl_D = 0;
        A3_W = 0; WD3_W = 0; WE3_W = 0; flush_E = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [4:0]  a1, a2, rd, a3;
        logic [31:0] rd1, rd2, wd3;
        logic        we3, mr, fl;
        logic        x_stall, x_valid;
        logic [31:0] x_rd1, x_rd2;
        logic [15:0] x_cnt;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] a1, a2, rd, input logic [31:0] rd1, rd2,
                                input logic [4:0] a3, input logic [31:0] wd3,
                                input logic we3, mr, fl, xs, xv,
                                input logic [31:0] xr1, xr2, input logic [15:0] xc);
        vec_t v;
        v.a1 = a1; v.a2 = a2; v.rd = rd; v.rd1 = rd1; v.rd2 = rd2; v.a3 = a3; v.wd3 = wd3;
        v.we3 = we3; v.mr = mr; v.fl = fl; v.x_stall = xs; v.x_valid = xv;
        v.x_rd1 = xr1; v.x_rd2 = xr2; v.x_cnt = xc;
        return v;
    endfunction

    vec_t vecs[8];

    initial begin
        clear_inputs();
        reset = 1'b1;
        #2;
        model_reset();
        compare_all("reset");
        chk("reset stall_D", stall_D, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        // Re-sync: the first edge after release loaded all-zero inputs.
        model_reset(); m_valid = 1;
        compare_all("release");
        do_reset();

        // a1 a2 rd rd1 rd2 a3 wd3 we3 mr fl | stall valid RD1_E RD2_E cnt
        vecs[0] = mk(1, 2, 5, 32'd11, 32'd22, 0, 0, 0, 1, 0, 0, 1, 32'd11, 32'd22, 0);
        vecs[1] = mk(5, 3, 6, 32'd33, 32'd44, 0, 0, 0, 0, 0, 1, 0, 32'd0, 32'd0, 1);
        vecs[2] = mk(5, 3, 6, 32'd33, 32'd44, 0, 0, 0, 0, 0, 0, 1, 32'd33, 32'd44, 1);
        vecs[3] = mk(1, 7, 8, 32'd5, 32'd0, 7, 32'hDEADBEEF, 1, 0, 0, 0, 1, 32'd5, 32'hDEADBEEF, 1);
        vecs[4] = mk(0, 0, 0, 32'd99, 32'd77, 0, 32'h1234, 1, 1, 0, 0, 1, 32'd0, 32'd0, 1);
        vecs[5] = mk(0, 9, 3, 32'd55, 32'd5, 0, 0, 0, 0, 0, 0, 1, 32'd0, 32'd5, 1);
        vecs[6] = mk(1, 2, 4, 32'd1, 32'd2, 0, 0, 0, 1, 0, 0, 1, 32'd1, 32'd2, 1);
        vecs[7] = mk(4, 4, 1, 32'd8, 32'd9, 0, 0, 0, 0, 1, 1, 0, 32'd0, 32'd0, 2);

        for (int i = 0; i < 8; i++) begin
            A1_D = vecs[i].a1; A2_D = vecs[i].a2; rd_D = vecs[i].rd;
            RD1_D = vecs[i].rd1; RD2_D = vecs[i].rd2;
            A3_W = vecs[i].a3; WD3_W = vecs[i].wd3; WE3_W = vecs[i].we3;
            MemRead_D = vecs[i].mr; flush_E = vecs[i].fl;
            #1;
            chk($sformatf("vec%0d stall_D", i), stall_D, vecs[i].x_stall);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d valid_E", i), valid_E, vecs[i].x_valid);
            chk($sformatf("vec%0d RD1_E", i), RD1_E, vecs[i].x_rd1);
            chk($sformatf("vec%0d RD2_E", i), RD2_E, vecs[i].x_rd2);
            chk($sformatf("vec%0d bubble_cnt", i), bubble_cnt, vecs[i].x_cnt);
        end

        // Random traffic against the model; small address range forces collisions.
        clear_inputs();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            A1_D = 5'($urandom_range(0, 7)); A2_D = 5'($urandom_range(0, 7));
            rd_D = 5'($urandom_range(0, 7)); A3_W = 5'($urandom_range(0, 7));
            RD1_D = $urandom; RD2_D = $urandom; WD3_W = $urandom;
            imm_D = $urandom; pc_D = $urandom;
            WE3_W = 1'($urandom); RegWrite_D = 1'($urandom);
            MemRead_D = ($urandom_range(0, 2) == 0); MemWrite_D = 1'($urandom);
            ALUSrc_D = 1'($urandom); ALUControl_D = 3'($urandom);
            flush_E = ($urandom_range(0, 7) == 0);
            #1;
            chk("rand stall_D", stall_D, model_hazard());
            @(posedge clk);
            model_edge();
            #1;
            compare_all("rand");
        end

        // Counter saturation: drive 0xFFFE flush bubbles, then three more.
        clear_inputs();
        do_reset();
        flush_E = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat preload", bubble_cnt, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sat bubble%0d", i), bubble_cnt, 16'hFFFF);
        end
        flush_E = 1'b0;

        // Reset between edges while stalled, then release into a normal load.
        do_reset();
        rd_D = 5; MemRead_D = 1; A1_D = 1; RegWrite_D = 1;
        @(posedge clk);
        #1;
        A1_D = 5; rd_D = 9; MemRead_D = 0; imm_D = 32'h77;
        #1;
        chk("midstall stall_D before reset", stall_D, 1);
        reset = 1'b1;
        #1;
        chk("midstall stall_D", stall_D, 0);
        model_reset();
        compare_all("midstall reset");
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post-release valid_E", valid_E, 1);
        chk("post-release rd_E", rd_E, 9);
        chk("post-release imm_E", imm_E, 32'h77);
        chk("post-release bubble_cnt", bubble_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
